// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / control unit.
package pipe_hazard_ctrl_pkg;

   // EX operand source select codes driven onto o_Fwd_A / o_Fwd_B
   typedef enum logic [1:0] {
      FWD_REG = 2'b00,   // register file read
      FWD_MEM = 2'b01,   // EX/MEM ALU result
      FWD_WB  = 2'b10    // WB write data
   } fwd_sel_e;

   // The younger producer (MEM) wins over the older one (WB)
   function automatic fwd_sel_e fwd_pick(input logic mem_hit, input logic wb_hit);
      if (mem_hit) return FWD_MEM;
      if (wb_hit)  return FWD_WB;
      return FWD_REG;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// One producer/consumer comparison: a stage that really writes a register
// against a source operand that is really read.
module hazard_match #(
   parameter int REG_AW = 3
) (
   input  logic              eff_write,
   input  logic [REG_AW-1:0] dest,
   input  logic [REG_AW-1:0] src,
   input  logic              uses,
   output logic              match
);

   assign match = eff_write & uses & (dest == src);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage core: shadows the
// EX/MEM/WB destination state, raises stalls and flushes, selects EX operand
// forwarding and counts retired instructions.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW     = 3,
   parameter int FORWARD_EN = 1,
   parameter int ZERO_REG   = 1,
   parameter int CNT_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] i_Rs,
   input  logic [REG_AW-1:0] i_Rt,
   input  logic              i_Uses_Rs,
   input  logic              i_Uses_Rt,
   input  logic [REG_AW-1:0] i_Dest,
   input  logic              i_Sig_RegWrite,
   input  logic              i_Sig_MemRead,
   input  logic              i_Branch_Taken,
   output logic              o_Stall,
   output logic              o_Bubble_Ex,
   output logic              o_Flush_If_Id,
   output logic              o_Flush_Id_Ex,
   output logic              o_Flush_Ex_Mem,
   output logic [1:0]        o_Fwd_A,
   output logic [1:0]        o_Fwd_B,
   output logic [CNT_W-1:0]  o_Retired
);

   typedef struct packed {
      logic              valid;
      logic              regwrite;
      logic [REG_AW-1:0] dest;
   } dst_t;

   typedef struct packed {
      dst_t dst;
      logic memread;
   } wr_t;

   typedef struct packed {
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic              uses_rs;
      logic              uses_rt;
   } src_t;

   logic             id_valid_q;
   wr_t              ex_q;
   src_t             ex_src_q;
   wr_t              mem_q;
   dst_t             wb_q;
   logic [CNT_W-1:0] retired_q;

   logic     flush, stall, raw;
   fwd_sel_e fwd_a, fwd_b;

   // A write to the hardwired zero register is not a real write
   function automatic logic eff_write(input dst_t d);
      return d.valid & d.regwrite & !((ZERO_REG != 0) && (d.dest == '0));
   endfunction

   logic ex_eff, mem_eff, mem_alu_eff, wb_eff;
   assign ex_eff      = eff_write(ex_q.dst);
   assign mem_eff     = eff_write(mem_q.dst);
   assign mem_alu_eff = mem_eff & ~mem_q.memread;  // load data is not ready in MEM
   assign wb_eff      = eff_write(wb_q);

   logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
   logic fwd_mem_a, fwd_mem_b, fwd_wb_a, fwd_wb_b;

   // ID sources against the EX and MEM producers (stall detection)
   hazard_match #(.REG_AW(REG_AW)) u_ex_rs  (.eff_write(ex_eff),  .dest(ex_q.dst.dest),  .src(i_Rs), .uses(i_Uses_Rs), .match(ex_rs_hit));
   hazard_match #(.REG_AW(REG_AW)) u_ex_rt  (.eff_write(ex_eff),  .dest(ex_q.dst.dest),  .src(i_Rt), .uses(i_Uses_Rt), .match(ex_rt_hit));
   hazard_match #(.REG_AW(REG_AW)) u_mem_rs (.eff_write(mem_eff), .dest(mem_q.dst.dest), .src(i_Rs), .uses(i_Uses_Rs), .match(mem_rs_hit));
   hazard_match #(.REG_AW(REG_AW)) u_mem_rt (.eff_write(mem_eff), .dest(mem_q.dst.dest), .src(i_Rt), .uses(i_Uses_Rt), .match(mem_rt_hit));

   // EX sources against the MEM and WB producers (forwarding)
   hazard_match #(.REG_AW(REG_AW)) u_fm_a (.eff_write(mem_alu_eff), .dest(mem_q.dst.dest), .src(ex_src_q.rs), .uses(ex_src_q.uses_rs), .match(fwd_mem_a));
   hazard_match #(.REG_AW(REG_AW)) u_fm_b (.eff_write(mem_alu_eff), .dest(mem_q.dst.dest), .src(ex_src_q.rt), .uses(ex_src_q.uses_rt), .match(fwd_mem_b));
   hazard_match #(.REG_AW(REG_AW)) u_fw_a (.eff_write(wb_eff),      .dest(wb_q.dest),      .src(ex_src_q.rs), .uses(1'b1),              .match(fwd_wb_a));
   hazard_match #(.REG_AW(REG_AW)) u_fw_b (.eff_write(wb_eff),      .dest(wb_q.dest),      .src(ex_src_q.rt), .uses(1'b1),              .match(fwd_wb_b));

   // Same-cycle stall, flush and forward decisions; a taken branch overrides a stall
   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      flush = i_Branch_Taken & mem_q.dst.valid;
      raw   = 1'b0;
      fwd_a = FWD_REG;
      fwd_b = FWD_REG;
      if (FORWARD_EN != 0) begin
         raw   = ex_q.memread & (ex_rs_hit | ex_rt_hit);
         fwd_a = fwd_pick(fwd_mem_a, fwd_wb_a);
         fwd_b = fwd_pick(fwd_mem_b, fwd_wb_b);
      end else begin
         raw   = ex_rs_hit | ex_rt_hit | mem_rs_hit | mem_rt_hit;
      end
      stall = raw & ~flush;
   end

   assign o_Stall        = stall;
   assign o_Bubble_Ex    = stall;
   assign o_Flush_If_Id  = flush;
   assign o_Flush_Id_Ex  = flush;
   assign o_Flush_Ex_Mem = flush;
   assign o_Fwd_A        = fwd_a;
   assign o_Fwd_B        = fwd_b;
   assign o_Retired      = retired_q;

   // Advance the shadow pipeline; squashed or stalled slots become bubbles
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_valid_q <= 1'b0;
         ex_q       <= '0;
         ex_src_q   <= '0;
         mem_q      <= '0;
         wb_q       <= '0;
      end else begin
         // NOTE: non-blocking assignments so every stage moves on the pre-edge values.
         wb_q  <= mem_q.dst;
         mem_q <= flush ? '0 : ex_q;
         if (flush || stall) begin
            ex_q     <= '0;
            ex_src_q <= '0;
         end else begin
            ex_q     <= '{dst: '{valid: id_valid_q, regwrite: i_Sig_RegWrite, dest: i_Dest},
                          memread: i_Sig_MemRead};
            ex_src_q <= '{rs: i_Rs, rt: i_Rt, uses_rs: i_Uses_Rs, uses_rt: i_Uses_Rt};
         end
         if (flush)       id_valid_q <= 1'b0;
         else if (!stall) id_valid_q <= 1'b1;
      end
   end

   // Count instructions leaving WB; wraps naturally at the counter width
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           retired_q <= '0;
      else if (wb_q.valid) retired_q <= retired_q + CNT_W'(1);
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (default, FORWARD_EN=0, CNT_W=4)
// share one ID stimulus stream and are compared every cycle against an
// instruction-level model of the pipeline plus directed scenario checks.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] rs, rt, dest;
   logic       uses_rs, uses_rt, regwrite, memread, branch_taken;

   logic       stall_o [3];
   logic       bubble_o [3];
   logic       fl_ifid_o [3];
   logic       fl_idex_o [3];
   logic       fl_exmem_o [3];
   logic [1:0] fwd_a_o [3];
   logic [1:0] fwd_b_o [3];
   logic [31:0] ret0, ret1;
   logic [3:0]  ret2;

   always #5 clk = ~clk;

   pipe_hazard_ctrl u0 (
      .clk(clk), .reset(reset), .i_Rs(rs), .i_Rt(rt), .i_Uses_Rs(uses_rs), .i_Uses_Rt(uses_rt),
      .i_Dest(dest), .i_Sig_RegWrite(regwrite), .i_Sig_MemRead(memread), .i_Branch_Taken(branch_taken),
      .o_Stall(stall_o[0]), .o_Bubble_Ex(bubble_o[0]), .o_Flush_If_Id(fl_ifid_o[0]),
      .o_Flush_Id_Ex(fl_idex_o[0]), .o_Flush_Ex_Mem(fl_exmem_o[0]),
      .o_Fwd_A(fwd_a_o[0]), .o_Fwd_B(fwd_b_o[0]), .o_Retired(ret0));

   pipe_hazard_ctrl #(.FORWARD_EN(0)) u1 (
      .clk(clk), .reset(reset), .i_Rs(rs), .i_Rt(rt), .i_Uses_Rs(uses_rs), .i_Uses_Rt(uses_rt),
      .i_Dest(dest), .i_Sig_RegWrite(regwrite), .i_Sig_MemRead(memread), .i_Branch_Taken(branch_taken),
      .o_Stall(stall_o[1]), .o_Bubble_Ex(bubble_o[1]), .o_Flush_If_Id(fl_ifid_o[1]),
      .o_Flush_Id_Ex(fl_idex_o[1]), .o_Flush_Ex_Mem(fl_exmem_o[1]),
      .o_Fwd_A(fwd_a_o[1]), .o_Fwd_B(fwd_b_o[1]), .o_Retired(ret1));

   pipe_hazard_ctrl #(.CNT_W(4)) u2 (
      .clk(clk), .reset(reset), .i_Rs(rs), .i_Rt(rt), .i_Uses_Rs(uses_rs), .i_Uses_Rt(uses_rt),
      .i_Dest(dest), .i_Sig_RegWrite(regwrite), .i_Sig_MemRead(memread), .i_Branch_Taken(branch_taken),
      .o_Stall(stall_o[2]), .o_Bubble_Ex(bubble_o[2]), .o_Flush_If_Id(fl_ifid_o[2]),
      .o_Flush_Id_Ex(fl_idex_o[2]), .o_Flush_Ex_Mem(fl_exmem_o[2]),
      .o_Fwd_A(fwd_a_o[2]), .o_Fwd_B(fwd_b_o[2]), .o_Retired(ret2));

   // ---------------- instruction-level reference model ----------------
   typedef struct {
      bit v; bit rw; bit mr;
      int dest; int rs; int rt;
      bit urs; bit urt;
   } instr_t;

   instr_t      ex_m [3], mem_m [3], wb_m [3];
   bit          idv_m [3];
   int unsigned ret_m [3];
   instr_t      cur_in;
   int          checks = 0, failures = 0, cyc = 0;
   string       fname [8];

   function automatic instr_t mk(int d, int s, int t, bit us, bit ut, bit w, bit m);
      instr_t x;
      x.v = 1'b1; x.rw = w; x.mr = m; x.dest = d; x.rs = s; x.rt = t; x.urs = us; x.urt = ut;
      return x;
   endfunction
   function automatic instr_t alu(int d, int s, int t); return mk(d, s, t, 1, 1, 1, 0); endfunction
   function automatic instr_t load(int d, int b);       return mk(d, b, 0, 1, 0, 1, 1); endfunction
   function automatic instr_t beq(int s, int t);        return mk(0, s, t, 1, 1, 0, 0); endfunction
   function automatic instr_t nop();                    return mk(0, 0, 0, 0, 0, 0, 0); endfunction
   function automatic instr_t empty_slot();
      instr_t x = mk(0, 0, 0, 0, 0, 0, 0);
      x.v = 1'b0;
      return x;
   endfunction

   // All instances keep register 0 hardwired
   function automatic bit writes(instr_t s); return s.v && s.rw && (s.dest != 0); endfunction
   function automatic bit id_reads(int r);
      return (uses_rs && (int'(rs) == r)) || (uses_rt && (int'(rt) == r));
   endfunction
   function automatic bit fwd_on(int k); return k != 1; endfunction

   function automatic bit exp_flush(int k); return branch_taken && mem_m[k].v; endfunction

   function automatic bit exp_stall(int k);
      bit hz;
      if (fwd_on(k))
         hz = writes(ex_m[k]) && ex_m[k].mr && id_reads(ex_m[k].dest);
      else
         hz = (writes(ex_m[k]) && id_reads(ex_m[k].dest)) || (writes(mem_m[k]) && id_reads(mem_m[k].dest));
      return hz && !exp_flush(k);
   endfunction

   function automatic int exp_fwd(int k, int r, bit u);
      if (!fwd_on(k)) return 0;
      if (u && writes(mem_m[k]) && !mem_m[k].mr && mem_m[k].dest == r) return 1;
      if (writes(wb_m[k]) && wb_m[k].dest == r) return 2;
      return 0;
   endfunction

   function automatic logic [31:0] ret_of(int k);
      case (k)
         0:       return ret0;
         1:       return ret1;
         default: return {28'd0, ret2};
      endcase
   endfunction

   function automatic logic [31:0] ret_mask(int k); return (k == 2) ? 32'hF : 32'hFFFF_FFFF; endfunction

   function automatic logic [10:0] out_bits(int k);
      return {stall_o[k], bubble_o[k], fl_ifid_o[k], fl_idex_o[k], fl_exmem_o[k], fwd_a_o[k], fwd_b_o[k], 2'b00};
   endfunction

   task automatic clear_model();
      for (int k = 0; k < 3; k++) begin
         ex_m[k] = empty_slot(); mem_m[k] = empty_slot(); wb_m[k] = empty_slot();
         idv_m[k] = 1'b0; ret_m[k] = 0;
      end
   endtask

   // Present one ID instruction (and branch/reset inputs), then compare every instance
   task automatic drive(input instr_t in, input bit bt, input bit rst);
      logic [31:0] got [8];
      logic [31:0] exp [8];
      #1;
      cur_in = in;
      rs = 3'(in.rs); rt = 3'(in.rt); dest = 3'(in.dest);
      uses_rs = in.urs; uses_rt = in.urt; regwrite = in.rw; memread = in.mr;
      branch_taken = bt; reset = rst;
      if (rst) clear_model();
      #1;
      for (int k = 0; k < 3; k++) begin
         got[0] = 32'(stall_o[k]);    exp[0] = 32'(exp_stall(k));
         got[1] = 32'(bubble_o[k]);   exp[1] = 32'(exp_stall(k));
         got[2] = 32'(fl_ifid_o[k]);  exp[2] = 32'(exp_flush(k));
         got[3] = 32'(fl_idex_o[k]);  exp[3] = 32'(exp_flush(k));
         got[4] = 32'(fl_exmem_o[k]); exp[4] = 32'(exp_flush(k));
         got[5] = 32'(fwd_a_o[k]);    exp[5] = 32'(exp_fwd(k, ex_m[k].rs, ex_m[k].urs));
         got[6] = 32'(fwd_b_o[k]);    exp[6] = 32'(exp_fwd(k, ex_m[k].rt, ex_m[k].urt));
         got[7] = ret_of(k);          exp[7] = ret_m[k] & ret_mask(k);
         for (int j = 0; j < 8; j++) begin
            checks++;
            if (got[j] !== exp[j]) begin
               failures++;
               $display("FAIL %s dut=%0d cyc=%0d got=%0h exp=%0h", fname[j], k, cyc, got[j], exp[j]);
            end
         end
      end
   endtask

   // Move every instance's model one clock forward, then wait for the edge
   task automatic advance();
      bit     fl, st;
      instr_t idi;
      for (int k = 0; k < 3; k++) begin
         if (!reset) begin
            fl = exp_flush(k);
            st = exp_stall(k);
            idi = cur_in;
            idi.v = idv_m[k];
            if (wb_m[k].v) ret_m[k]++;
            wb_m[k]  = mem_m[k];
            mem_m[k] = fl ? empty_slot() : ex_m[k];
            ex_m[k]  = (fl || st) ? empty_slot() : idi;
            if (fl)       idv_m[k] = 1'b0;
            else if (!st) idv_m[k] = 1'b1;
         end
      end
      cyc++;
      @(posedge clk);
   endtask

   task automatic step(input instr_t in);
      drive(in, 1'b0, 1'b0);
      advance();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(nop(), 1'b1, 1'b1);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_bits(k) !== '0 || ret_of(k) !== 32'd0) begin
               failures++;
               $display("FAIL reset_outputs dut=%0d got=%0h/%0h exp=0/0", k, out_bits(k), ret_of(k));
            end
         end
         advance();
      end
   endtask

   task automatic test_independent();
      instr_t in;
      for (int i = 0; i < 8; i++) begin
         in = (i >= 1 && i <= 4) ? alu(i, 6, 7) : nop();
         drive(in, 1'b0, 1'b0);
         checks++;
         if ({stall_o[0], stall_o[1], fl_ifid_o[0], fwd_a_o[0], fwd_b_o[0], fwd_a_o[1], fwd_b_o[1]} !== '0) begin
            failures++;
            $display("FAIL indep_quiet cyc=%0d got=%b exp=0", cyc,
                     {stall_o[0], stall_o[1], fl_ifid_o[0], fwd_a_o[0], fwd_b_o[0], fwd_a_o[1], fwd_b_o[1]});
         end
         advance();
      end
      drive(nop(), 1'b0, 1'b0);
      checks++;
      if (ret0 !== 32'd4 || ret1 !== 32'd4) begin
         failures++;
         $display("FAIL indep_retired got=%0d/%0d exp=4/4", ret0, ret1);
      end
      advance();
   endtask

   task automatic test_forward();
      step(alu(3, 1, 2));
      step(alu(4, 3, 1));
      drive(nop(), 1'b0, 1'b0);
      checks++;
      if (fwd_a_o[0] !== 2'b01 || stall_o[0] !== 1'b0) begin
         failures++;
         $display("FAIL fwd_mem got=%b/%b exp=01/0", fwd_a_o[0], stall_o[0]);
      end
      advance();
      step(alu(3, 1, 2));
      step(nop());
      step(alu(4, 3, 1));
      drive(nop(), 1'b0, 1'b0);
      checks++;
      if (fwd_a_o[0] !== 2'b10) begin
         failures++;
         $display("FAIL fwd_wb got=%b exp=10", fwd_a_o[0]);
      end
      advance();
   endtask

   task automatic test_load_use();
      step(load(2, 1));
      drive(alu(5, 2, 2), 1'b0, 1'b0);
      checks++;
      if (stall_o[0] !== 1'b1 || bubble_o[0] !== 1'b1) begin
         failures++;
         $display("FAIL load_use_stall got=%b/%b exp=1/1", stall_o[0], bubble_o[0]);
      end
      advance();
      drive(alu(5, 2, 2), 1'b0, 1'b0);
      checks++;
      if (stall_o[0] !== 1'b0) begin
         failures++;
         $display("FAIL load_use_release got=%b exp=0", stall_o[0]);
      end
      advance();
      drive(nop(), 1'b0, 1'b0);
      checks++;
      if (fwd_a_o[0] !== 2'b10 || fwd_b_o[0] !== 2'b10) begin
         failures++;
         $display("FAIL load_use_fwd got=%b/%b exp=10/10", fwd_a_o[0], fwd_b_o[0]);
      end
      advance();
   endtask

   task automatic test_branch_flush();
      logic [31:0] r_before;
      step(beq(6, 7));
      step(load(2, 1));
      drive(alu(5, 2, 2), 1'b1, 1'b0);
      checks++;
      if ({fl_ifid_o[0], fl_idex_o[0], fl_exmem_o[0], stall_o[0], bubble_o[0]} !== 5'b11100) begin
         failures++;
         $display("FAIL branch_flush got=%b exp=11100",
                  {fl_ifid_o[0], fl_idex_o[0], fl_exmem_o[0], stall_o[0], bubble_o[0]});
      end
      r_before = ret0;
      advance();
      for (int i = 0; i < 4; i++) begin
         drive(nop(), 1'b0, 1'b0);
         if (i == 3) begin
            checks++;
            if (ret0 - r_before !== 32'd2) begin
               failures++;
               $display("FAIL branch_retired got=%0d exp=2", ret0 - r_before);
            end
         end
         advance();
      end
   endtask

   task automatic test_no_forward();
      int  stalls = 0;
      bit  s;
      for (int i = 0; i < 3; i++) step(nop());
      step(alu(0, 1, 2));
      drive(alu(5, 0, 0), 1'b0, 1'b0);
      checks++;
      if (stall_o[1] !== 1'b0) begin
         failures++;
         $display("FAIL zero_reg_stall got=%b exp=0", stall_o[1]);
      end
      advance();
      step(alu(3, 1, 2));
      for (int i = 0; i < 6; i++) begin
         drive(alu(4, 3, 3), 1'b0, 1'b0);
         s = stall_o[1];
         if (s) stalls++;
         checks++;
         if (fwd_a_o[1] !== 2'b00 || fwd_b_o[1] !== 2'b00) begin
            failures++;
            $display("FAIL nofwd_sel got=%b/%b exp=00/00", fwd_a_o[1], fwd_b_o[1]);
         end
         advance();
         if (!s) break;
      end
      checks++;
      if (stalls != 2) begin
         failures++;
         $display("FAIL nofwd_stall_cycles got=%0d exp=2", stalls);
      end
   endtask

   task automatic test_wrap();
      drive(nop(), 1'b0, 1'b1);
      advance();
      for (int i = 0; i < 22; i++) begin
         drive(nop(), 1'b0, 1'b0);
         if (i == 21) begin
            checks++;
            if (ret2 !== 4'd1 || ret0 !== 32'd17) begin
               failures++;
               $display("FAIL retired_wrap got=%0d/%0d exp=1/17", ret2, ret0);
            end
         end
         advance();
      end
   endtask

   task automatic test_random();
      instr_t cur = nop();
      bit     last_stall = 1'b0;
      bit     rst, bt, w;
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         bt  = ($urandom_range(0, 7) == 0);
         if (!last_stall) begin
            w   = 1'($urandom_range(0, 1));
            cur = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w,
                     w && ($urandom_range(0, 2) == 0));
         end
         drive(cur, bt, rst);
         if (rst) begin
            for (int k = 0; k < 3; k++) begin
               checks++;
               if (out_bits(k) !== '0 || ret_of(k) !== 32'd0) begin
                  failures++;
                  $display("FAIL midstream_reset dut=%0d got=%0h/%0h exp=0/0", k, out_bits(k), ret_of(k));
               end
            end
         end
         last_stall = exp_stall(0);
         advance();
      end
   endtask

   initial begin
      fname[0] = "stall";       fname[1] = "bubble";       fname[2] = "flush_if_id";
      fname[3] = "flush_id_ex"; fname[4] = "flush_ex_mem"; fname[5] = "fwd_a";
      fname[6] = "fwd_b";       fname[7] = "retired";
      reset = 1'b1;
      rs = '0; rt = '0; dest = '0;
      uses_rs = 1'b0; uses_rt = 1'b0; regwrite = 1'b0; memread = 1'b0; branch_taken = 1'b0;
      cur_in = nop();
      clear_model();
      @(posedge clk);
      test_reset();
      test_independent();
      test_forward();
      test_load_use();
      test_branch_flush();
      test_no_forward();
      test_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
